// File: rtl/buart_xfifo.sv
// UART with FIFOs on both directions, start-bit glitch rejection, sticky
// framing/overflow flags and a transmit-complete indication.
module buart_xfifo #(
  parameter int FREQ_MHZ = 12,
  parameter int BAUDS    = 115200,
  parameter int RX_AW    = 3,
  parameter int TX_AW    = 3
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       rx,
  output logic       tx,
  input  logic       wr,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       tx_idle,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       valid,
  output logic       rx_overflow,
  output logic       rx_frame_err,
  input  logic       clr_err
);
  localparam int DIV = FREQ_MHZ * 1000000 / BAUDS;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  // ---------------- transmit FIFO ----------------
  logic [7:0]     tx_mem [2**TX_AW];
  logic [TX_AW:0] tx_wp, tx_rp;
  logic           tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]) && (tx_wp[TX_AW] != tx_rp[TX_AW]);
  assign tx_push  = wr && !tx_full;
  assign busy     = tx_full;

  typedef enum logic [1:0] {T_GUARD, T_IDLE, T_SHIFT} tstate_t;
  tstate_t       tstate;
  logic [CW-1:0] tcnt;
  logic [3:0]    tbit;
  logic [9:0]    tshift;

  // A new frame is loaded from IDLE or straight after the stop bit, so frames abut.
  assign tx_pop = !tx_empty &&
                  ((tstate == T_IDLE) ||
                   (tstate == T_SHIFT && tcnt == DIV_LAST && tbit == 4'd9));

  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wp[TX_AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      tstate  <= T_GUARD;
      tcnt    <= '0;
      tbit    <= '0;
      tshift  <= '1;
      tx      <= 1'b1;
      tx_idle <= 1'b0;
    end else begin
      tx      <= tshift[0];
      tx_idle <= (tstate == T_IDLE) && tx_empty;
      case (tstate)
        T_GUARD: begin
          if (tcnt == DIV_LAST) begin
            tcnt <= '0;
            if (tbit == 4'd9) begin
              tbit   <= '0;
              tstate <= T_IDLE;
            end else begin
              tbit <= tbit + 1'b1;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        T_IDLE: begin
          if (tx_pop) begin
            tshift <= {1'b1, tx_mem[tx_rp[TX_AW-1:0]], 1'b0};
            tcnt   <= '0;
            tbit   <= '0;
            tstate <= T_SHIFT;
          end
        end
        T_SHIFT: begin
          if (tcnt == DIV_LAST) begin
            tcnt <= '0;
            if (tbit == 4'd9) begin
              tbit <= '0;
              if (tx_pop)
                tshift <= {1'b1, tx_mem[tx_rp[TX_AW-1:0]], 1'b0};
              else
                tstate <= T_IDLE;
            end else begin
              tbit   <= tbit + 1'b1;
              tshift <= {1'b1, tshift[9:1]};
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: tstate <= T_IDLE;
      endcase
    end
  end

  // ---------------- receive path ----------------
  logic rx_meta, rs;

  always_ff @(posedge clk) begin
    if (!resetq) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
    end
  end

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rstate_t;
  rstate_t       rstate;
  logic [CW-1:0] rcnt;
  logic [2:0]    rbit;
  logic [7:0]    rshift;

  logic [7:0]     rx_mem [2**RX_AW];
  logic [RX_AW:0] rx_wp, rx_rp;
  logic           rx_empty, rx_full, rx_pop, stop_sample, rx_push, rx_drop, frame_bad;

  assign rx_empty    = (rx_wp == rx_rp);
  assign rx_full     = (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]) && (rx_wp[RX_AW] != rx_rp[RX_AW]);
  assign rx_pop      = rd && !rx_empty;
  assign stop_sample = (rstate == R_STOP) && (rcnt == DIV_LAST);
  // A full FIFO still takes the byte when the head is popped in the same cycle.
  assign rx_push     = stop_sample && rs && (!rx_full || rd);
  assign rx_drop     = stop_sample && rs && rx_full && !rd;
  assign frame_bad   = stop_sample && !rs;
  assign rx_data     = rx_mem[rx_rp[RX_AW-1:0]];
  assign valid       = !rx_empty;

  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[rx_wp[RX_AW-1:0]] <= rshift;
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      rx_wp        <= '0;
      rx_rp        <= '0;
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (clr_err) begin
        rx_overflow  <= 1'b0;
        rx_frame_err <= 1'b0;
      end else begin
        if (rx_drop)   rx_overflow  <= 1'b1;
        if (frame_bad) rx_frame_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      rstate <= R_IDLE;
      rcnt   <= '0;
      rbit   <= '0;
      rshift <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (!rs) begin
            rcnt   <= '0;
            rstate <= R_START;
          end
        end
        R_START: begin
          if (rcnt == HALF_LAST) begin
            rcnt   <= '0;
            rbit   <= '0;
            rstate <= rs ? R_IDLE : R_DATA;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        R_DATA: begin
          if (rcnt == DIV_LAST) begin
            rcnt   <= '0;
            rshift <= {rs, rshift[7:1]};
            rbit   <= rbit + 1'b1;
            if (rbit == 3'd7) rstate <= R_STOP;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        R_STOP: begin
          if (rcnt == DIV_LAST) begin
            rcnt   <= '0;
            rstate <= rs ? R_IDLE : R_BREAK;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        R_BREAK: begin
          if (rs) rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_buart_xfifo.sv
// Directed bench for buart_xfifo at DIV=10 with 4-entry FIFOs.
module tb_buart_xfifo;
  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       resetq = 1'b0;
  logic       rx = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic       tx, busy, tx_idle, valid, rx_overflow, rx_frame_err;
  logic [7:0] rx_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  buart_xfifo #(.FREQ_MHZ(1), .BAUDS(100000), .RX_AW(2), .TX_AW(2)) dut (
    .clk(clk), .resetq(resetq), .rx(rx), .tx(tx), .wr(wr), .tx_data(tx_data),
    .busy(busy), .tx_idle(tx_idle), .rd(rd), .rx_data(rx_data), .valid(valid),
    .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err), .clr_err(clr_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) tick();
    end
    rx = stop;
    repeat (DIV) tick();
    $display("rx frame driven: data=0x%02h stop=%0b", b, stop);
  endtask

  task automatic test_reset;
    resetq = 1'b0; rx = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    repeat (3) tick();
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (tx_idle !== 1'b0) begin n_bad++; $display("FAIL reset_tx_idle: got %b want 0", tx_idle); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (rx_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", rx_overflow); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", rx_frame_err); end
    $display("reset checked");
    resetq = 1'b1;
  endtask

  // wr lands on the first GUARD edge; GUARD spans 100 edges, then IDLE pops and tx falls one edge later.
  task automatic test_tx_single;
    logic [9:0] frame;
    int fall;
    frame = {1'b1, 8'h55, 1'b0};
    wr = 1'b1; tx_data = 8'h55;
    tick();
    wr = 1'b0;
    fall = 0;
    for (int k = 1; k <= 300 && fall == 0; k++) begin
      tick();
      if (tx === 1'b0) fall = k;
    end
    n_cmp++; if (fall != 101) begin n_bad++; $display("FAIL tx55_start_edge: got %0d want 101", fall); end
    repeat (5) tick();
    for (int b = 0; b < 10; b++) begin
      if (b > 0) repeat (DIV) tick();
      n_cmp++; if (tx !== frame[b]) begin n_bad++; $display("FAIL tx55_bit%0d: got %b want %b", b, tx, frame[b]); end
      if (b == 5) begin
        n_cmp++; if (tx_idle !== 1'b0) begin n_bad++; $display("FAIL tx55_idle_during: got %b want 0", tx_idle); end
      end
    end
    repeat (6) tick();
    n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL tx55_idle_after: got %b want 1", tx_idle); end
    $display("tx frame 0x55 checked");
  endtask

  task automatic test_back_to_back;
    logic [9:0] frame;
    int c, bad;
    resetq = 1'b0;
    repeat (3) tick();
    resetq = 1'b1;
    wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data = 8'(i + 1);
      tick();
      if (i == 2) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_3: got %b want 0", busy); end
      end
    end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_4: got %b want 1", busy); end
    tx_data = 8'hFF;
    tick();
    wr = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_5th: got %b want 1", busy); end
    c = 4;
    while (tx !== 1'b0 && c < 400) begin
      tick();
      c++;
    end
    n_cmp++; if (c != 101) begin n_bad++; $display("FAIL b2b_start_edge: got %0d want 101", c); end
    repeat (5) tick();
    for (int f = 0; f < 4; f++) begin
      frame = {1'b1, 8'(f + 1), 1'b0};
      bad = 0;
      for (int b = 0; b < 10; b++) begin
        if (!(f == 0 && b == 0)) repeat (DIV) tick();
        if (tx !== frame[b]) bad++;
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL b2b_frame%0d: got %0d wrong bits want 0", f, bad); end
      $display("tx frame 0x%02h checked", 8'(f + 1));
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_drained: got %b want 0", busy); end
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL b2b_no_extra_frame: got %0d low cycles want 0", bad); end
    n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL b2b_tx_idle: got %b want 1", tx_idle); end
  endtask

  task automatic test_rx_basic;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rx_valid_before: got %b want 0", valid); end
    send_rx(8'hA3, 1'b1);
    rx = 1'b1;
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL rx_valid: got %b want 1", valid); end
    n_cmp++; if (rx_data !== 8'hA3) begin n_bad++; $display("FAIL rx_data_a3: got %02h want a3", rx_data); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rx_valid_after_rd: got %b want 0", valid); end
  endtask

  task automatic test_rx_overflow;
    for (int i = 0; i < 4; i++) send_rx(8'((i + 1) * 17), 1'b1);
    n_cmp++; if (rx_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_before: got %b want 0", rx_overflow); end
    send_rx(8'h55, 1'b1);
    rx = 1'b1;
    n_cmp++; if (rx_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", rx_overflow); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rx_data !== 8'((i + 1) * 17)) begin n_bad++; $display("FAIL ovf_data%0d: got %02h want %02h", i, rx_data, 8'((i + 1) * 17)); end
      rd = 1'b1;
      tick();
      rd = 1'b0;
    end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %b want 0", valid); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++; if (rx_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", rx_overflow); end
  endtask

  task automatic test_frame_err;
    send_rx(8'h5A, 1'b0);
    repeat (50) tick();
    n_cmp++; if (rx_frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_set: got %b want 1", rx_frame_err); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ferr_no_push: got %b want 0", valid); end
    rx = 1'b1;
    repeat (20) tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ferr_no_spurious: got %b want 0", valid); end
    send_rx(8'h3C, 1'b1);
    rx = 1'b1;
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL ferr_next_valid: got %b want 1", valid); end
    n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL ferr_next_data: got %02h want 3c", rx_data); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_cmp++; if (rx_frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_sticky: got %b want 1", rx_frame_err); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_clear: got %b want 0", rx_frame_err); end
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (30) tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL glitch_no_push: got %b want 0", valid); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL glitch_no_ferr: got %b want 0", rx_frame_err); end
    send_rx(8'h96, 1'b1);
    rx = 1'b1;
    n_cmp++; if (rx_data !== 8'h96 || valid !== 1'b1) begin n_bad++; $display("FAIL glitch_recover: got %b/%02h want 1/96", valid, rx_data); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic test_reset_mid_tx;
    int c, bad;
    wr = 1'b1; tx_data = 8'hC3;
    tick();
    tx_data = 8'h00;
    tick();
    wr = 1'b0;
    c = 0;
    while (tx !== 1'b0 && c < 50) begin
      tick();
      c++;
    end
    repeat (30) tick();
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pre: got %b want 0", tx); end
    resetq = 1'b0;
    tick();
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
    n_cmp++; if (tx_idle !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle: got %b want 0", tx_idle); end
    repeat (2) tick();
    resetq = 1'b1;
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rst_mid_flushed: got %0d low cycles want 0", bad); end
    n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL rst_mid_idle_after: got %b want 1", tx_idle); end
    $display("reset mid-frame checked");
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_basic();
    test_rx_overflow();
    test_frame_err();
    test_glitch();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/buart_xfifo.md
# buart_xfifo

Parametrised second-generation UART with configurable-depth FIFOs on both receive and transmit sides, start-bit glitch rejection, framing-error and overflow detection, and a transmit-complete indication. Sits between the CPU I/O register decode and the board serial pins. Byte-level handshake (wr/rd/busy/valid) is unchanged from the single-FIFO UART, so existing drivers keep working; the new status outputs are optional.

## Interface
- FREQ_MHZ, 12: system clock in MHz.
- BAUDS, 115200: line rate. DIV = FREQ_MHZ*1000000/BAUDS (integer, must be >= 4); counter width $clog2(DIV+1).
- RX_AW, 3: rx FIFO depth = 2**RX_AW entries, all usable.
- TX_AW, 3: tx FIFO depth = 2**TX_AW entries, all usable.

- clk  in  1  single clock; all logic on posedge.
- resetq  in  1  synchronous, active-low reset.
- rx  in  1  serial input, asynchronous; passed through a 2-flop synchroniser.
- tx  out  1  serial output, registered.
- wr  in  1  push tx_data into tx FIFO.
- tx_data  in  8  byte to send.
- busy  out  1  tx FIFO full.
- tx_idle  out  1  tx FIFO empty and shifter idle (last stop bit finished).
- rd  in  1  pop rx FIFO head.
- rx_data  out  8  rx FIFO head (first-word fall-through).
- valid  out  1  rx FIFO non-empty.
- rx_overflow  out  1  sticky: received byte dropped, FIFO full.
- rx_frame_err  out  1  sticky: stop bit sampled low.
- clr_err  in  1  clears both sticky flags.

## Operation
- FIFOs: read/write pointers AW+1 bits wide; empty = pointers equal, full = equal low bits with differing MSB. Wrap-around natural.
- wr while full: ignored, no state change. rd while empty: ignored.
- Rx push while full: accepted if rd asserted same cycle, else dropped and rx_overflow set.
- Rx FSM (on synchronised rx, rs): IDLE -> START on rs=0, counter cleared. START: after DIV/2 cycles sample; rs=1 -> IDLE (glitch), rs=0 -> DATA. DATA: every DIV cycles shift in one bit, LSB first; after 8 bits -> STOP. STOP: after DIV cycles sample; rs=1 -> push byte, IDLE; rs=0 -> discard, set rx_frame_err, -> BREAK. BREAK: wait for rs=1, -> IDLE.
- Tx FSM: GUARD -> IDLE -> SHIFT. After reset, GUARD holds tx=1 for 10*DIV cycles; FIFO accepts writes meanwhile. IDLE with FIFO non-empty: pop head, load {1, byte, 0}, -> SHIFT. SHIFT: each bit held exactly DIV cycles; after stop bit, pop next byte directly if available (no idle gap), else IDLE.
- clr_err has priority over set in the same cycle.

## Timing
- Reset values: tx=1, busy=0, tx_idle=0 (GUARD), valid=0, rx_overflow=0, rx_frame_err=0, rx_data don't-care; both FIFOs empty, both FSMs at GUARD/IDLE.
- Reset mid-frame: frame abandoned, tx high cycle after reset edge, FIFO contents discarded, GUARD restarts.
- tx_idle rises the cycle after GUARD ends if FIFO empty.
- wr at edge T into empty FIFO with tx FSM IDLE: tx falls at edge T+2; tx_idle low from T+1.
- Frame length 10*DIV cycles; back-to-back frames contiguous.
- Rx: valid rises the cycle after the stop-bit sample edge; rx_data stable and valid in that same cycle.
- rd at edge T: valid/rx_data reflect the new head after edge T.
- busy updates the cycle after the wr that fills the FIFO.

## Test plan
- FREQ_MHZ=1, BAUDS=100000 (DIV=10), RX_AW=TX_AW=2 for all. Reset 3 cycles, wr 0x55 at cycle 0 of GUARD -> tx high 100 cycles, then start bit, bits 1,0,1,0,1,0,1,0, stop, each 10 cycles; tx_idle high after stop.
- Write 0x01,0x02,0x03,0x04 back-to-back -> busy high after 4th wr, 5th wr 0xFF ignored; four contiguous frames, no 0xFF on line.
- Drive rx with 0xA3 at 10 cycles/bit -> valid rises, rx_data=0xA3; rd -> valid=0.
- Send 5 bytes with no rd -> first four readable in order, rx_overflow=1; clr_err -> 0.
- Frame with stop bit 0, then rx held low 50 cycles -> rx_frame_err=1, no push, no spurious frame until rx returns high; next good byte 0x3C received.
- 3-cycle low pulse on idle rx -> no push, FSM back to IDLE; reset asserted mid-tx frame -> tx=1 next cycle, FIFO empty.
